// File: rtl/cla_pkg.sv
// Shared constants and parameter legality checks for the pipelined CLA adder.
package cla_pkg;

  localparam int unsigned GROUP_W = 4;

  function automatic bit width_legal(input int unsigned w);
    return (w >= 4) && (w <= 64) && ((w % GROUP_W) == 0);
  endfunction

  function automatic bit stages_legal(input int unsigned w, input int unsigned s);
    return (s >= 1) && (((w / GROUP_W) % s) == 0);
  endfunction

endpackage

// File: rtl/cla4_group.sv
// Four-bit carry-lookahead group with group propagate/generate outputs.
module cla4_group
  import cla_pkg::*;
(
  input  logic [GROUP_W-1:0] a,
  input  logic [GROUP_W-1:0] b,
  input  logic               ci,
  output logic [GROUP_W-1:0] s,
  output logic               P,
  output logic               G,
  output logic               co
);

  logic [GROUP_W-1:0] prop;
  logic [GROUP_W-1:0] gen;
  logic [GROUP_W-1:0] c;

  assign prop = a ^ b;
  assign gen  = a & b;

  assign c[0] = ci;
  assign c[1] = gen[0] | (prop[0] & ci);
  assign c[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & ci);
  assign c[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
              | (prop[2] & prop[1] & prop[0] & ci);

  assign P  = &prop;
  assign G  = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
            | (prop[3] & prop[2] & prop[1] & gen[0]);
  assign co = G | (P & ci);
  assign s  = prop ^ c;

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead add/subtract with valid/ready flow control.
// Optional signed-overflow flag enabled by defining CLA_PIPE_OVF_EN.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NG  = WIDTH / GROUP_W;
  localparam int unsigned GPS = NG / STAGES;
  localparam int unsigned SW  = GPS * GROUP_W;

  if (!width_legal(WIDTH) || !stages_legal(WIDTH, STAGES)) begin : g_bad_cfg
    $error("cla_pipe_adder: illegal WIDTH/STAGES combination");
  end

  logic             adv_c;
  logic [WIDTH-1:0] b_eff;
  logic             c_in0;

  // Whole pipe moves together; a stalled output freezes every stage.
  assign adv_c    = out_ready | ~out_valid;
  assign in_ready = adv_c & RST_N;
  assign b_eff    = sub ? ~b : b;
  assign c_in0    = sub | cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned REM = WIDTH - k * SW;
    localparam int unsigned LO  = (k + 1) * SW;

    logic           v_i;
    logic           c_i;
    logic [REM-1:0] a_i;
    logic [REM-1:0] b_i;
    logic [SW-1:0]  s_c;
    logic [GPS:0]   gc;
    logic [GPS-1:0] gp;
    logic [GPS-1:0] gg;
    logic           c_out_c;
    logic [LO-1:0]  lo_new_c;
    logic           vld_d, vld_q;
    logic           c_d, c_q;
    logic [LO-1:0]  lo_d, lo_q;

    if (k == 0) begin : g_src
      assign v_i      = in_valid;
      assign c_i      = c_in0;
      assign a_i      = a;
      assign b_i      = b_eff;
      assign lo_new_c = s_c;
    end else begin : g_src
      assign v_i      = g_stage[k-1].vld_q;
      assign c_i      = g_stage[k-1].c_q;
      assign a_i      = g_stage[k-1].g_hi.hi_a_q;
      assign b_i      = g_stage[k-1].g_hi.hi_b_q;
      assign lo_new_c = {s_c, g_stage[k-1].lo_q};
    end

    assign gc[0] = c_i;
    for (genvar j = 0; j < GPS; j++) begin : g_grp
      cla4_group u_grp (
        .a  (a_i[j*GROUP_W +: GROUP_W]),
        .b  (b_i[j*GROUP_W +: GROUP_W]),
        .ci (gc[j]),
        .s  (s_c[j*GROUP_W +: GROUP_W]),
        .P  (gp[j]),
        .G  (gg[j]),
        .co (gc[j+1])
      );
    end

    // Stage carry-out resolved from group P/G rather than the group ripple.
    always_comb begin
      c_out_c = c_i;
      for (int j = 0; j < GPS; j++) begin
        c_out_c = gg[j] | (gp[j] & c_out_c);
      end
    end

    always_comb begin
      vld_d = vld_q;
      c_d   = c_q;
      lo_d  = lo_q;
      if (adv_c) begin
        vld_d = v_i;
        if (v_i) begin
          c_d  = c_out_c;
          lo_d = lo_new_c;
        end
      end
    end

    always_ff @(posedge CLK) begin
      if (!RST_N) begin
        vld_q <= 1'b0;
        c_q   <= 1'b0;
        lo_q  <= '0;
      end else begin
        vld_q <= vld_d;
        c_q   <= c_d;
        lo_q  <= lo_d;
      end
    end

    if (k < STAGES - 1) begin : g_hi
      logic [REM-SW-1:0] hi_a_d, hi_a_q;
      logic [REM-SW-1:0] hi_b_d, hi_b_q;

      always_comb begin
        hi_a_d = hi_a_q;
        hi_b_d = hi_b_q;
        if (adv_c && v_i) begin
          hi_a_d = a_i[REM-1:SW];
          hi_b_d = b_i[REM-1:SW];
        end
      end

      always_ff @(posedge CLK) begin
        if (!RST_N) begin
          hi_a_q <= '0;
          hi_b_q <= '0;
        end else begin
          hi_a_q <= hi_a_d;
          hi_b_q <= hi_b_d;
        end
      end
    end

`ifdef CLA_PIPE_OVF_EN
    if (k == STAGES - 1) begin : g_last
      logic ovf_d, ovf_q;

      // Carry into the MSB recovered from its sum bit and operand bits.
      always_comb begin
        ovf_d = ovf_q;
        if (adv_c && v_i) begin
          ovf_d = c_out_c ^ (s_c[SW-1] ^ a_i[SW-1] ^ b_i[SW-1]);
        end
      end

      always_ff @(posedge CLK) begin
        if (!RST_N) begin
          ovf_q <= 1'b0;
        end else begin
          ovf_q <= ovf_d;
        end
      end
    end
`endif
  end

  assign out_valid = g_stage[STAGES-1].vld_q;
  assign sum       = g_stage[STAGES-1].lo_q;
  assign cout      = g_stage[STAGES-1].c_q;
`ifdef CLA_PIPE_OVF_EN
  assign ovf       = g_stage[STAGES-1].g_last.ovf_q;
`else
  assign ovf       = 1'b0;
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed self-checking bench for cla_pipe_adder (WIDTH=16, STAGES=2).
module tb_cla_pipe_adder;

  localparam int unsigned W  = 16;
  localparam int unsigned ST = 2;
`ifdef CLA_PIPE_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         RST_N;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int n_vec = 0;
  int n_err = 0;

  cla_pipe_adder #(.WIDTH(W), .STAGES(ST)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (op_a),
    .b         (op_b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 CLK = ~CLK;

  // Reference: {ovf, cout, sum}; overflow from operand/result sign comparison.
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic ci, input logic s);
    logic [W-1:0] yy;
    logic [W:0]   r;
    logic         o;
    yy = s ? ~y : y;
    r  = {1'b0, x} + {1'b0, yy} + (W+1)'(s ? 1'b1 : ci);
    o  = (x[W-1] == yy[W-1]) && (r[W-1] != x[W-1]);
    return {o & OVF_EN, r};
  endfunction

  task automatic drive(input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic ci, input logic s);
    in_valid = v;
    op_a     = x;
    op_b     = y;
    cin      = ci;
    sub      = s;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_vec++; if (sum !== 16'h0000) begin n_err++; $display("FAIL reset_sum: got %h expected 0000", sum); end
    n_vec++; if ({cout, ovf} !== 2'b00) begin n_err++; $display("FAIL reset_cout_ovf: got %b expected 00", {cout, ovf}); end
    next_cycle();
    RST_N = 1'b1;
    out_ready = 1'b1;
  endtask

  task automatic test_add();
    drive(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    @(negedge CLK);
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL add_in_ready: got %b expected 1", in_ready); end
    next_cycle();
    in_valid = 1'b0;
    @(negedge CLK);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL add_latency_early: got %b expected 0", out_valid); end
    next_cycle();
    @(negedge CLK);
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL add_out_valid: got %b expected 1", out_valid); end
    n_vec++; if ({ovf, cout, sum} !== {1'b0, 1'b1, 16'h0000})
      begin n_err++; $display("FAIL add_result: got %h expected %h", {ovf, cout, sum}, {1'b0, 1'b1, 16'h0000}); end
    next_cycle();
    @(negedge CLK);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL add_no_dup: got %b expected 0", out_valid); end
  endtask

  task automatic test_sub();
    drive(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1);
    next_cycle();
    drive(1'b1, 16'h0003, 16'h0005, 1'b1, 1'b1);
    @(negedge CLK);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL sub_early: got %b expected 0", out_valid); end
    next_cycle();
    in_valid = 1'b0;
    @(negedge CLK);
    n_vec++; if ({out_valid, ovf, cout, sum} !== {1'b1, OVF_EN, 1'b1, 16'h7FFF})
      begin n_err++; $display("FAIL sub_8000_0001: got %h expected %h", {out_valid, ovf, cout, sum}, {1'b1, OVF_EN, 1'b1, 16'h7FFF}); end
    next_cycle();
    @(negedge CLK);
    n_vec++; if ({out_valid, ovf, cout, sum} !== {1'b1, 1'b0, 1'b0, 16'hFFFE})
      begin n_err++; $display("FAIL sub_0003_0005: got %h expected %h", {out_valid, ovf, cout, sum}, {1'b1, 1'b0, 1'b0, 16'hFFFE}); end
    next_cycle();
    @(negedge CLK);
    n_vec++; if ({out_valid, cout, sum} !== {1'b0, 1'b0, 16'hFFFE})
      begin n_err++; $display("FAIL sub_idle_hold: got %h expected %h", {out_valid, cout, sum}, {1'b0, 1'b0, 16'hFFFE}); end
  endtask

  task automatic test_carry_chain();
    drive(1'b1, 16'h7FFF, 16'h0000, 1'b1, 1'b0);
    next_cycle();
    in_valid = 1'b0;
    next_cycle();
    @(negedge CLK);
    n_vec++; if ({out_valid, ovf, cout, sum} !== {1'b1, OVF_EN, 1'b0, 16'h8000})
      begin n_err++; $display("FAIL carry_chain: got %h expected %h", {out_valid, ovf, cout, sum}, {1'b1, OVF_EN, 1'b0, 16'h8000}); end
    next_cycle();
  endtask

  task automatic test_backpressure();
    logic [W-1:0]   xa  [3];
    logic [W-1:0]   xb  [3];
    logic           xc  [3];
    logic           xs  [3];
    logic [W+1:0]   xr  [3];
    logic [W+1:0]   expq[$];
    int             sent = 0;
    int             got  = 0;
    xa = '{16'h1234, 16'hFFF0, 16'h8001};
    xb = '{16'h4321, 16'h0020, 16'h8001};
    xc = '{1'b1, 1'b0, 1'b0};
    xs = '{1'b0, 1'b1, 1'b0};
    xr = '{{1'b0, 1'b0, 16'h5556}, {1'b0, 1'b1, 16'hFFD0}, {OVF_EN, 1'b1, 16'h0002}};
    for (int cyc = 0; cyc < 10; cyc++) begin
      out_ready = (cyc >= 5);
      if (sent < 3) drive(1'b1, xa[sent], xb[sent], xc[sent], xs[sent]);
      else          in_valid = 1'b0;
      @(negedge CLK);
      n_vec++; if (in_ready !== ((cyc < 2) || (cyc >= 5)))
        begin n_err++; $display("FAIL bp_in_ready cyc %0d: got %b expected %b", cyc, in_ready, (cyc < 2) || (cyc >= 5)); end
      n_vec++; if (out_valid !== ((cyc >= 2) && (cyc <= 7)))
        begin n_err++; $display("FAIL bp_out_valid cyc %0d: got %b expected %b", cyc, out_valid, (cyc >= 2) && (cyc <= 7)); end
      if (out_valid === 1'b1 && expq.size() > 0) begin
        n_vec++; if ({ovf, cout, sum} !== expq[0])
          begin n_err++; $display("FAIL bp_result cyc %0d: got %h expected %h", cyc, {ovf, cout, sum}, expq[0]); end
        if (out_ready) begin
          void'(expq.pop_front());
          got++;
        end
      end
      if (in_valid && in_ready) begin
        expq.push_back(xr[sent]);
        sent++;
      end
      next_cycle();
    end
    n_vec++; if (got != 3 || expq.size() != 0)
      begin n_err++; $display("FAIL bp_count: got %0d results (%0d pending) expected 3", got, expq.size()); end
  endtask

  task automatic test_stream();
    logic [W+1:0] expq[$];
    int           got = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 100 + ST + 2; cyc++) begin
      if (cyc < 100) drive(1'b1, W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else           in_valid = 1'b0;
      @(negedge CLK);
      if (cyc < 100) begin
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stream_in_ready cyc %0d: got %b expected 1", cyc, in_ready); end
      end
      n_vec++; if (out_valid !== ((cyc >= ST) && (cyc < 100 + ST)))
        begin n_err++; $display("FAIL stream_out_valid cyc %0d: got %b expected %b", cyc, out_valid, (cyc >= ST) && (cyc < 100 + ST)); end
      if (out_valid === 1'b1 && expq.size() > 0) begin
        n_vec++; if ({ovf, cout, sum} !== expq[0])
          begin n_err++; $display("FAIL stream_result cyc %0d: got %h expected %h", cyc, {ovf, cout, sum}, expq[0]); end
        void'(expq.pop_front());
        got++;
      end
      if (in_valid && in_ready) expq.push_back(ref_add(op_a, op_b, cin, sub));
      next_cycle();
    end
    n_vec++; if (got != 100) begin n_err++; $display("FAIL stream_count: got %0d expected 100", got); end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b1;
    drive(1'b1, 16'h0101, 16'h0202, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0);
    next_cycle();
    in_valid = 1'b0;
    RST_N = 1'b0;
    @(negedge CLK);
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_mid_in_ready: got %b expected 0", in_ready); end
    n_vec++; if ({out_valid, sum} !== {1'b1, 16'h0303})
      begin n_err++; $display("FAIL rst_mid_inflight: got %h expected %h", {out_valid, sum}, {1'b1, 16'h0303}); end
    next_cycle();
    RST_N = 1'b1;
    drive(1'b1, 16'h0F0F, 16'h00F1, 1'b0, 1'b0);
    @(negedge CLK);
    n_vec++; if ({out_valid, cout, sum} !== {1'b0, 1'b0, 16'h0000})
      begin n_err++; $display("FAIL rst_mid_flush: got %h expected %h", {out_valid, cout, sum}, {1'b0, 1'b0, 16'h0000}); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %b expected 1", in_ready); end
    next_cycle();
    in_valid = 1'b0;
    for (int cyc = 1; cyc < 6; cyc++) begin
      @(negedge CLK);
      n_vec++; if (out_valid !== (cyc == 2))
        begin n_err++; $display("FAIL rst_mid_stale cyc %0d: got %b expected %b", cyc, out_valid, cyc == 2); end
      if (cyc == 2) begin
        n_vec++; if ({ovf, cout, sum} !== {1'b0, 1'b0, 16'h1000})
          begin n_err++; $display("FAIL rst_first_op: got %h expected %h", {ovf, cout, sum}, {1'b0, 1'b0, 16'h1000}); end
      end
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_carry_chain();
    test_backpressure();
    test_stream();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
